// File: rtl/dht_onewire_reader_if.sv
// Host-side bus of the DHT single-wire reader: read request, received bytes and status strobes.
interface dht_onewire_reader_if;
    logic       start;
    logic       mode;
    logic [7:0] hum_i;
    logic [7:0] hum_f;
    logic [7:0] temp_i;
    logic [7:0] temp_f;
    logic [7:0] csum;
    logic       valid;
    logic       crc_err;
    logic       timeout_err;
    logic       busy;

    modport master (
        output start, mode,
        input  hum_i, hum_f, temp_i, temp_f, csum,
        input  valid, crc_err, timeout_err, busy
    );

    modport slave (
        input  start, mode,
        output hum_i, hum_f, temp_i, temp_f, csum,
        output valid, crc_err, timeout_err, busy
    );
endinterface

// File: rtl/dht_onewire_reader.sv
// DHT11/DHT22 single-wire reader: host start pulse, microsecond-timed response and
// 40-bit capture, checksum verification and an enforced idle holdoff between reads.
module dht_onewire_reader #(
    parameter int CLK_HZ         = 50000000,
    parameter int START_LOW_US   = 18000,
    parameter int START_LOW22_US = 1100,
    parameter int TIMEOUT_US     = 200,
    parameter int BIT_THRESH_US  = 50,
    parameter int HOLDOFF_US     = 1000000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    inout  wire                  data,
    dht_onewire_reader_if.slave  bus
);

    localparam int DIV = CLK_HZ / 1000000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int UW  = 21;

    localparam logic [PW-1:0] PRESC_MAX  = PW'(DIV - 1);
    localparam logic [UW-1:0] T_START11  = UW'(START_LOW_US);
    localparam logic [UW-1:0] T_START22  = UW'(START_LOW22_US);
    localparam logic [UW-1:0] T_TIMEOUT  = UW'(TIMEOUT_US);
    localparam logic [UW-1:0] T_THRESH   = UW'(BIT_THRESH_US);
    localparam logic [UW-1:0] T_HOLDOFF  = UW'(HOLDOFF_US);

    typedef enum logic [3:0] {
        IDLE,
        START_LOW,
        WAIT_RESP,
        RESP_LOW,
        RESP_HIGH,
        BIT_LOW,
        BIT_HIGH,
        CHECK,
        HOLDOFF
    } state_t;

    state_t                  state;
    logic [PW-1:0]           presc;
    logic                    us_tick;
    logic [UW-1:0]           us_cnt;
    logic [UW-1:0]           us_now;
    logic [SYNC_STAGES-1:0]  sync_p;
    logic                    pin;
    logic                    pin_d;
    logic                    fall;
    logic                    rise;
    logic                    advance;
    logic                    timed_out;
    logic                    bit_val;
    logic                    mode_q;
    logic [UW-1:0]           start_len;
    logic                    drive_low;
    logic [39:0]             shift_sr;
    logic [5:0]              bit_cnt;
    logic [39:0]             frame_q;
    logic                    valid_q;
    logic                    crc_q;
    logic                    timeout_q;
    logic                    busy_q;

    function automatic logic csum_ok(input logic [39:0] f);
        logic [7:0] s;
        s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
        return s == f[7:0];
    endfunction

    function automatic state_t phase_next(input state_t s);
        case (s)
            WAIT_RESP: return RESP_LOW;
            RESP_LOW:  return RESP_HIGH;
            RESP_HIGH: return BIT_LOW;
            BIT_LOW:   return BIT_HIGH;
            default:   return IDLE;
        endcase
    endfunction

    // Open-drain pad: only ever pulls low, otherwise released to the pull-up.
    assign data = drive_low ? 1'b0 : 1'bz;

    assign us_tick = (presc == PRESC_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
        end else if (us_tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p <= '1;
            pin_d  <= 1'b1;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], data};
            pin_d  <= sync_p[SYNC_STAGES-1];
        end
    end

    assign pin  = sync_p[SYNC_STAGES-1];
    assign fall = pin_d & ~pin;
    assign rise = ~pin_d & pin;

    // Counting this cycle's tick makes a phase of N whole microseconds read as exactly N.
    assign us_now    = us_cnt + UW'(us_tick);
    assign timed_out = (us_now >= T_TIMEOUT);
    assign bit_val   = (us_now > T_THRESH);
    assign start_len = mode_q ? T_START22 : T_START11;

    always_comb begin
        advance = 1'b0;
        case (state)
            WAIT_RESP: advance = fall;
            RESP_LOW:  advance = rise;
            RESP_HIGH: advance = fall;
            BIT_LOW:   advance = rise;
            BIT_HIGH:  advance = fall;
            default:   advance = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            us_cnt    <= '0;
            mode_q    <= 1'b0;
            drive_low <= 1'b0;
            shift_sr  <= '0;
            bit_cnt   <= '0;
            frame_q   <= '0;
            valid_q   <= 1'b0;
            crc_q     <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            crc_q     <= 1'b0;
            timeout_q <= 1'b0;
            us_cnt    <= us_now;
            case (state)
                IDLE: begin
                    us_cnt <= '0;
                    if (bus.start) begin
                        mode_q    <= bus.mode;
                        busy_q    <= 1'b1;
                        drive_low <= 1'b1;
                        shift_sr  <= '0;
                        bit_cnt   <= '0;
                        state     <= START_LOW;
                    end
                end
                START_LOW: begin
                    if (us_now >= start_len) begin
                        drive_low <= 1'b0;
                        us_cnt    <= '0;
                        state     <= WAIT_RESP;
                    end
                end
                WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW: begin
                    if (advance) begin
                        us_cnt <= '0;
                        state  <= phase_next(state);
                    end else if (timed_out) begin
                        us_cnt    <= '0;
                        shift_sr  <= '0;
                        bit_cnt   <= '0;
                        timeout_q <= 1'b1;
                        state     <= HOLDOFF;
                    end
                end
                BIT_HIGH: begin
                    if (advance) begin
                        shift_sr <= {shift_sr[38:0], bit_val};
                        bit_cnt  <= bit_cnt + 6'd1;
                        us_cnt   <= '0;
                        state    <= (bit_cnt == 6'd39) ? CHECK : BIT_LOW;
                    end else if (timed_out) begin
                        us_cnt    <= '0;
                        shift_sr  <= '0;
                        bit_cnt   <= '0;
                        timeout_q <= 1'b1;
                        state     <= HOLDOFF;
                    end
                end
                CHECK: begin
                    us_cnt <= '0;
                    state  <= HOLDOFF;
                    if (csum_ok(shift_sr)) begin
                        frame_q <= shift_sr;
                        valid_q <= 1'b1;
                    end else begin
                        crc_q <= 1'b1;
                    end
                end
                HOLDOFF: begin
                    if (us_now >= T_HOLDOFF) begin
                        us_cnt <= '0;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    us_cnt    <= '0;
                    drive_low <= 1'b0;
                    busy_q    <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.hum_i       = frame_q[39:32];
    assign bus.hum_f       = frame_q[31:24];
    assign bus.temp_i      = frame_q[23:16];
    assign bus.temp_f      = frame_q[15:8];
    assign bus.csum        = frame_q[7:0];
    assign bus.valid       = valid_q;
    assign bus.crc_err     = crc_q;
    assign bus.timeout_err = timeout_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_dht_onewire_reader.sv
// Bench for dht_onewire_reader: a DHT sensor model on the shared pin, randomized frames,
// and a frame-level reference that states what bytes, strobes and phase lengths must be.
module tb_dht_onewire_reader;

    localparam int CLK_HZ         = 1000000;
    localparam int START_LOW_US   = 100;
    localparam int START_LOW22_US = 20;
    localparam int TIMEOUT_US     = 200;
    localparam int BIT_THRESH_US  = 50;
    localparam int HOLDOFF_US     = 50;
    localparam int SYNC_STAGES    = 2;

    logic clk = 1'b0;
    logic rst;
    logic sensor_low;
    wire  data;

    always #5 clk = ~clk;

    assign data = sensor_low ? 1'b0 : 1'bz;
    pullup (data);

    dht_onewire_reader_if bus ();

    dht_onewire_reader #(
        .CLK_HZ(CLK_HZ),
        .START_LOW_US(START_LOW_US),
        .START_LOW22_US(START_LOW22_US),
        .TIMEOUT_US(TIMEOUT_US),
        .BIT_THRESH_US(BIT_THRESH_US),
        .HOLDOFF_US(HOLDOFF_US),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data(data),
        .bus(bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [39:0] exp_frame = '0;
    bit          start_window  = 1'b0;
    bit          strobe_window = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    endtask

    // Reference frame rule: checksum is the low byte of the sum of the first four bytes.
    function automatic bit frame_good(input logic [39:0] f);
        int s;
        s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
        return (s % 256) == int'(f[7:0]);
    endfunction

    function automatic logic [39:0] make_frame(input bit good);
        logic [39:0] f;
        int          s;
        f[39:8] = $urandom;
        s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
        f[7:0] = 8'(s % 256);
        if (!good) f[7:0] = f[7:0] ^ (8'h01 << $urandom_range(7, 0));
        return f;
    endfunction

    // Continuous comparison against the reference on every cycle.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            check("bytes", {bus.hum_i, bus.hum_f, bus.temp_i, bus.temp_f, bus.csum}, exp_frame);
            if (!strobe_window)
                check("no_strobe", {bus.valid, bus.crc_err, bus.timeout_err}, 3'b000);
            if (!start_window)
                check("no_host_drive", (data === 1'b0) && !sensor_low, 1'b0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input bit m, output int lc);
        start_window = 1'b1;
        bus.mode  = m;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.mode  = ~m;
        lc = 0;
        while (data === 1'b0 && lc < 40000) begin
            lc++;
            @(negedge clk);
        end
        check("busy_after_start", bus.busy, 1'b1);
        start_window = 1'b0;
    endtask

    task automatic sense_frame(input logic [39:0] f, input int hmode, input int abort_bit,
                               output bit aborted);
        bit b;
        int hl;
        aborted = 1'b0;
        repeat ($urandom_range(40, 20)) @(negedge clk);
        sensor_low = 1'b1;
        repeat (80) @(negedge clk);
        sensor_low = 1'b0;
        repeat (80) @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            b = f[39-i];
            sensor_low = 1'b1;
            repeat ($urandom_range(55, 30)) @(negedge clk);
            sensor_low = 1'b0;
            if (i == abort_bit) begin
                aborted = 1'b1;
                return;
            end
            if (hmode == 1) hl = b ? BIT_THRESH_US + 1 : BIT_THRESH_US;
            else hl = b ? $urandom_range(80, BIT_THRESH_US + 1) : $urandom_range(BIT_THRESH_US, 20);
            repeat (hl) @(negedge clk);
        end
        sensor_low = 1'b1;
    endtask

    task automatic wait_holdoff(input bit poke);
        int cnt;
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 4 * HOLDOFF_US + 20) begin
            cnt++;
            @(negedge clk);
            if (cnt == 1) begin
                strobe_window = 1'b0;
                sensor_low    = 1'b0;
            end
            if (poke && cnt == 10) bus.start = 1'b1;
            if (poke && cnt == 11) bus.start = 1'b0;
        end
        bus.start = 1'b0;
        check("holdoff_us", cnt, HOLDOFF_US);
        if (poke) begin
            repeat (5) @(negedge clk);
            check("start_in_holdoff_ignored", bus.busy, 1'b0);
        end
    endtask

    task automatic wait_strobe(input int limit, output int k, output logic [2:0] st);
        k = 0;
        while (!(bus.valid || bus.crc_err || bus.timeout_err) && k < limit) begin
            @(negedge clk);
            k++;
        end
        st = {bus.valid, bus.crc_err, bus.timeout_err};
    endtask

    task automatic run_read(input logic [39:0] f, input bit m, input int hmode, input bit poke);
        int         lc, k;
        bit         ab, good;
        logic [2:0] st;
        good = frame_good(f);
        do_start(m, lc);
        check("start_low_us", lc, m ? START_LOW22_US : START_LOW_US);
        sense_frame(f, hmode, -1, ab);
        strobe_window = 1'b1;
        wait_strobe(12, k, st);
        check("frame_strobe", st, good ? 3'b100 : 3'b010);
        if (good) exp_frame = f;
        wait_holdoff(poke);
    endtask

    task automatic run_timeout();
        int         lc, k;
        logic [2:0] st;
        do_start(1'b0, lc);
        check("start_low_us", lc, START_LOW_US);
        strobe_window = 1'b1;
        wait_strobe(1000, k, st);
        check("timeout_us", k, TIMEOUT_US);
        check("timeout_strobe", st, 3'b001);
        wait_holdoff(1'b0);
    endtask

    initial begin
        int  lc;
        bit  ab;
        rst        = 1'b1;
        sensor_low = 1'b0;
        bus.start  = 1'b0;
        bus.mode   = 1'b0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_strobes", {bus.valid, bus.crc_err, bus.timeout_err}, 3'b000);
        check("rst_pin_released", data, 1'b1);
        check("rst_hum_i", bus.hum_i, 8'h00);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        run_read(40'h37_00_19_00_51, 1'b0, 0, 1'b0);
        check("crc_keeps_reset_hum_i", bus.hum_i, 8'h00);

        run_read(40'h37_00_19_00_50, 1'b0, 0, 1'b0);
        check("good_hum_i", bus.hum_i, 8'h37);
        check("good_temp_i", bus.temp_i, 8'h19);
        check("good_csum", bus.csum, 8'h50);

        run_read(40'h37_00_19_00_51, 1'b0, 0, 1'b0);
        check("crc_keeps_hum_i", bus.hum_i, 8'h37);
        check("crc_keeps_temp_i", bus.temp_i, 8'h19);

        run_timeout();
        check("timeout_keeps_csum", bus.csum, 8'h50);

        run_read(40'h02_8C_01_5F_EE, 1'b1, 0, 1'b0);
        check("dht22_hum_f", bus.hum_f, 8'h8C);
        check("dht22_temp_f", bus.temp_f, 8'h5F);
        check("dht22_csum", bus.csum, 8'hEE);

        run_read(make_frame(1'b1), 1'b0, 1, 1'b1);
        run_read(40'hAA_55_00_FF_FE, 1'b0, 1, 1'b0);
        check("threshold_hum_f", bus.hum_f, 8'h55);

        for (int i = 0; i < 4; i++)
            run_read(make_frame(1'($urandom_range(1, 0))), 1'($urandom_range(1, 0)), 0, 1'b0);

        start_window = 1'b1;
        bus.mode  = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (30) @(negedge clk);
        check("host_drives_in_start", data, 1'b0);
        #2;
        exp_frame = '0;
        rst = 1'b0;
        #1;
        check("rst_in_start_pin_released", data, 1'b1);
        check("rst_in_start_busy", bus.busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        start_window = 1'b0;
        repeat (3) @(negedge clk);

        run_read(make_frame(1'b1), 1'b0, 0, 1'b0);

        do_start(1'b0, lc);
        check("start_low_us", lc, START_LOW_US);
        sense_frame(make_frame(1'b1), 0, 17, ab);
        repeat (10) @(negedge clk);
        #2;
        exp_frame = '0;
        rst = 1'b0;
        #1;
        check("rst_bit17_pin_released", data, 1'b1);
        check("rst_bit17_bytes", {bus.hum_i, bus.hum_f, bus.temp_i, bus.temp_f, bus.csum}, 40'h0);
        check("rst_bit17_busy", bus.busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        run_read(40'h41_07_16_03_61, 1'b0, 0, 1'b0);
        check("after_rst_hum_i", bus.hum_i, 8'h41);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dht_onewire_reader.md
Name: dht_onewire_reader

Overview:
Parametrised single-wire reader for DHT11/DHT22 temperature and humidity sensors. It drives the start pulse on a shared open-drain data pin and times the sensor response and the 40 data bits in microseconds. It verifies the checksum and presents the five received bytes with valid and error strobes. It sits between the sensor pad and the display/control logic. Compared with the earlier reader, it adds clock-rate independence, DHT22 mode, an input synchroniser, per-phase timeouts, checksum checking and an enforced re-read holdoff.

Parameters:
CLK_HZ, 50000000, system clock frequency; microsecond tick = CLK_HZ/1000000 cycles (must be integer ≥1)
START_LOW_US, 18000, host start-pulse low time in DHT11 mode
START_LOW22_US, 1100, host start-pulse low time in DHT22 mode
TIMEOUT_US, 200, max duration of any sensor-driven wait phase before abort
BIT_THRESH_US, 50, high-phase length above which a data bit is 1
HOLDOFF_US, 1000000, minimum idle time after any transaction end before next start accepted
SYNC_STAGES, 2, input synchroniser depth (≥2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
start  in  1  request a read; sampled only in IDLE
mode  in  1  0 = DHT11, 1 = DHT22; sampled with start
data  inout  1  sensor pin; block drives 0 or Z only, never 1
hum_i  out  8  byte 0 as received (humidity integer / DHT22 humidity MSB)
hum_f  out  8  byte 1
temp_i  out  8  byte 2
temp_f  out  8  byte 3
csum  out  8  byte 4 (checksum as received)
valid  out  1  1-cycle pulse: new bytes loaded, checksum OK
crc_err  out  1  1-cycle pulse: 40 bits received, checksum mismatch
timeout_err  out  1  1-cycle pulse: a phase exceeded TIMEOUT_US
busy  out  1  high from accepted start until holdoff expires

Behaviour:
- Reset: all byte outputs 0; valid, crc_err, timeout_err and busy 0; pin released (Z); synchroniser flops 1; state IDLE; counters 0. Reset mid-transaction releases the pin asynchronously and discards partial data.
- Prescaler: counts clk to CLK_HZ/1000000-1 and emits us_tick. The us counter (21 bits) clears on every state entry and increments on us_tick.
- Pin sampling: data passes through SYNC_STAGES flops. Edges are detected on the last stage versus a 1-cycle delayed copy. All phase decisions use synchronised edges.
- States:
  - IDLE: busy=0. On start=1, latch mode, set busy=1 and go to START_LOW.
  - START_LOW: drive 0. When us count reaches START_LOW_US (or START_LOW22_US if mode=1), release the pin and go to WAIT_RESP.
  - WAIT_RESP: go to RESP_LOW on a falling edge.
  - RESP_LOW: go to RESP_HIGH on a rising edge.
  - RESP_HIGH: go to BIT_LOW on a falling edge.
  - BIT_LOW: go to BIT_HIGH on a rising edge.
  - BIT_HIGH: on a falling edge, shift in bit = (us count > BIT_THRESH_US), MSB first, and increment bit_cnt. If bit_cnt reaches 40, go to CHECK; else go to BIT_LOW.
  - CHECK (1 cycle): if (b0+b1+b2+b3) mod 256 == b4, load all five outputs and pulse valid. Else pulse crc_err and leave outputs unchanged. Go to HOLDOFF.
  - HOLDOFF: pin released. After HOLDOFF_US, go to IDLE (busy=0).
- Timeout: in WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW and BIT_HIGH, the us count reaching TIMEOUT_US pulses timeout_err, discards the shift register and goes to HOLDOFF.
- Start while busy is ignored, not queued.
- Outputs always hold the last good reading.
- Bit exactly at threshold (us count == BIT_THRESH_US) decodes as 0.
- The pin is never driven outside START_LOW.

Test Plan:
- Setup for all tests: CLK_HZ=1000000, START_LOW_US=100, HOLDOFF_US=50, TIMEOUT_US=200.
- Sensor model sends 0x37,0x00,0x19,0x00,0x50 after a DHT11 start -> pin low exactly 100 us; valid pulses once; hum_i=0x37, temp_i=0x19, csum=0x50; busy drops 50 us after CHECK.
- Same frame with byte 4 = 0x51 -> crc_err pulses once; valid stays 0; outputs keep previous values (0x37/0x19 after the first test, 0 after reset).
- Sensor never responds -> timeout_err at 200 us after release; no output change; busy falls after holdoff.
- mode=1 with START_LOW22_US=20 and frame 0x02,0x8C,0x01,0x5F,0xEE -> start pulse 20 us; valid; bytes match.
- High phases of 50 us and 51 us -> decode as 0 and 1 respectively. A start pulse during HOLDOFF is ignored.
- Reset asserted during bit 17 -> pin Z immediately; all outputs 0; a new start after release yields a clean read.
